// File: rtl/ball_sched_pkg.sv
// Shared types and constants for the ball update scheduler.
// Ball state words are packed {p_x, p_y, v_x, v_y}, with p_x in the MSBs.
package ball_sched_pkg;

    localparam int WIDTH          = 32;
    localparam int FRAC_WIDTH     = 30;
    localparam int DEF_NUM_BALLS  = 16;
    localparam int DEF_IDX_W      = 4;
    localparam int DEF_TIMEOUT    = 64;

    localparam int STATE_W = 3;

    localparam int PX_OFS = 3 * WIDTH;
    localparam int PY_OFS = 2 * WIDTH;
    localparam int VX_OFS = WIDTH;
    localparam int VY_OFS = 0;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        SCAN,
        LOAD,
        KICK,
        WAIT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/ball_update_scheduler_timer.sv
// Per-ball WAIT counter.
// Qualifies datapath done (never in the first WAIT cycle) and flags the timeout.
module sched_wait_timer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic done_in,
    output logic done_ok,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (enable && cnt_reg != LAST_CNT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Count 0 is the first WAIT cycle, where a done left over from the previous ball may still be high.
    assign done_ok = enable && done_in && (cnt_reg != '0);
    assign expired = enable && !done_ok && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/ball_update_scheduler.sv
// Frame sequencer that time-shares one physics datapath across all balls.
// Each frame reads, updates and writes back every active ball in ascending index order.
module ball_update_scheduler
    import ball_sched_pkg::*;
#(
    parameter int NUM_BALLS = DEF_NUM_BALLS,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       delta_t,
    input  logic [WIDTH-1:0]       friction_coeff,
    input  logic [NUM_BALLS-1:0]   ball_active,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   all_stopped,
    output logic                   timeout_err,
    output logic                   rd_en,
    output logic [IDX_W-1:0]       rd_addr,
    input  logic [4*WIDTH-1:0]     rd_data,
    output logic                   wr_en,
    output logic [IDX_W-1:0]       wr_addr,
    output logic [4*WIDTH-1:0]     wr_data,
    output logic                   dp_rst,
    output logic [WIDTH-1:0]       dp_p_x,
    output logic [WIDTH-1:0]       dp_p_y,
    output logic [WIDTH-1:0]       dp_v_x,
    output logic [WIDTH-1:0]       dp_v_y,
    output logic [WIDTH-1:0]       dp_delta_t,
    output logic [WIDTH-1:0]       dp_friction,
    input  logic                   dp_done,
    input  logic [WIDTH-1:0]       dp_p_x_next,
    input  logic [WIDTH-1:0]       dp_p_y_next,
    input  logic [WIDTH-1:0]       dp_v_x_next,
    input  logic [WIDTH-1:0]       dp_v_y_next
);

    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(NUM_BALLS);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t               state_reg, state_next;
    logic [IDX_W:0]       idx_reg;
    logic [NUM_BALLS-1:0] active_reg;
    logic [(2**IDX_W)-1:0] active_pad;
    logic                 moving_reg;
    logic                 timeout_reg;
    logic [WIDTH-1:0]     dt_reg, fric_reg;
    logic [WIDTH-1:0]     px_reg, py_reg, vx_reg, vy_reg;
    logic [4*WIDTH-1:0]   result_reg;
    logic                 wait_done, wait_expired;

    // Pad the active mask to the full index range so idx lookups never go out of bounds.
    generate
        for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_active_pad
            if (gi < NUM_BALLS) begin : g_ball
                assign active_pad[gi] = active_reg[gi];
            end else begin : g_pad
                assign active_pad[gi] = 1'b0;
            end
        end
    endgenerate

    sched_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg == KICK),
        .enable  (state_reg == WAIT),
        .done_in (dp_done),
        .done_ok (wait_done),
        .expired (wait_expired)
    );

    always_comb begin
        state_next  = state_reg;
        busy        = 1'b1;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        dp_rst      = 1'b0;
        frame_done  = 1'b0;
        all_stopped = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = SCAN;
            end
            SCAN: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else if (active_pad[idx_reg[IDX_W-1:0]]) begin
                    rd_en      = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = KICK;
            KICK: begin
                dp_rst     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_done) state_next = WRITE;
                else if (wait_expired) state_next = SCAN;
            end
            WRITE: begin
                wr_en      = 1'b1;
                state_next = SCAN;
            end
            DONE: begin
                frame_done  = 1'b1;
                all_stopped = ~moving_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            active_reg  <= '0;
            moving_reg  <= 1'b0;
            timeout_reg <= 1'b0;
            dt_reg      <= '0;
            fric_reg    <= '0;
            px_reg      <= '0;
            py_reg      <= '0;
            vx_reg      <= '0;
            vy_reg      <= '0;
            result_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dt_reg      <= delta_t;
                        fric_reg    <= friction_coeff;
                        active_reg  <= ball_active;
                        idx_reg     <= '0;
                        moving_reg  <= 1'b0;
                        timeout_reg <= 1'b0;
                    end
                end
                SCAN: begin
                    if (idx_reg != LAST_IDX && !active_pad[idx_reg[IDX_W-1:0]])
                        idx_reg <= idx_reg + 1'b1;
                end
                LOAD: begin
                    px_reg <= rd_data[PX_OFS +: WIDTH];
                    py_reg <= rd_data[PY_OFS +: WIDTH];
                    vx_reg <= rd_data[VX_OFS +: WIDTH];
                    vy_reg <= rd_data[VY_OFS +: WIDTH];
                end
                WAIT: begin
                    if (wait_done) begin
                        result_reg <= {dp_p_x_next, dp_p_y_next, dp_v_x_next, dp_v_y_next};
                    end else if (wait_expired) begin
                        // Abandon the ball: its RAM entry stays as it was.
                        timeout_reg <= 1'b1;
                        idx_reg     <= idx_reg + 1'b1;
                    end
                end
                WRITE: begin
                    moving_reg <= moving_reg
                                | (result_reg[VX_OFS +: WIDTH] != '0)
                                | (result_reg[VY_OFS +: WIDTH] != '0);
                    idx_reg    <= idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign timeout_err = timeout_reg;
    assign rd_addr     = idx_reg[IDX_W-1:0];
    assign wr_addr     = idx_reg[IDX_W-1:0];
    assign wr_data     = result_reg;
    assign dp_p_x      = px_reg;
    assign dp_p_y      = py_reg;
    assign dp_v_x      = vx_reg;
    assign dp_v_y      = vy_reg;
    assign dp_delta_t  = dt_reg;
    assign dp_friction = fric_reg;

endmodule
